// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack pulse-crossing pair (transmitter and receiver).
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with async active-low reset.
module cdc_sync_bit
    import cdc_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_pulse_tx.sv
// Source side of the req/ack pulse crossing: queues events and drives a level request.
// Optional timeout abort is compiled in with CDC_PULSE_TX_TIMEOUT_EN.
module cdc_pulse_tx
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 4,
    parameter int TMO_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sig_in,
    input  logic             ack_in,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    output logic             tmo
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic             ack_s;
    logic             avail;
    logic             launch;
    logic             req_q;
    logic             ovf_q;
    logic             ovf_set;
    logic             tmo_hit;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (ack_in),
        .q    (ack_s)
    );

    assign avail = sig_in | (cnt_q != '0);

`ifdef CDC_PULSE_TX_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;

    assign tmo_hit = (state != IDLE) && (tmo_cnt == '1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == IDLE || state_nxt != state) ? '0 : tmo_cnt + 1'b1;
            tmo_q   <= tmo_q | tmo_hit;
        end
    end

    assign tmo = tmo_q;
`else
    assign tmo_hit = 1'b0;
    // TMO_W only has meaning when the timeout is compiled in
    assign tmo     = 1'b0 && (TMO_W > 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            req_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            req_q <= (state_nxt == REQ);
            cnt_q <= cnt_nxt;
            ovf_q <= ovf_q | ovf_set;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (avail) state_nxt = REQ;
            REQ:     if (ack_s) state_nxt = DROP;
            DROP:    if (!ack_s) state_nxt = avail ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
        // an aborted handshake still consumed its event; nothing is relaunched here
        if (tmo_hit) state_nxt = IDLE;
    end

    always_comb begin
        launch  = (state_nxt == REQ) && (state != REQ);
        cnt_nxt = cnt_q;
        ovf_set = 1'b0;
        if (sig_in && !launch) begin
            if (cnt_q == CNT_MAX) ovf_set = 1'b1;
            else                  cnt_nxt = cnt_q + 1'b1;
        end else if (!sig_in && launch) begin
            cnt_nxt = cnt_q - 1'b1;
        end
    end

    assign req_out  = req_q;
    assign busy     = (state != IDLE) || (cnt_q != '0);
    assign pend_cnt = cnt_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cdc_pulse_tx.sv
// Directed bench for cdc_pulse_tx with a 3-cycle ack loopback model of the receiver.
module tb_cdc_pulse_tx;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             sig_in;
    logic             ack_in;
    logic             req_out;
    logic             busy;
    logic [CNT_W-1:0] pend_cnt;
    logic             ovf;
    logic             tmo;

    int   total = 0;
    int   bad   = 0;
    int   edges = 0;
    logic prev_req = 1'b0;
    logic lb_en;
    logic [2:0] ack_d;

    typedef struct {
        logic             sig;
        logic             req;
        logic             bsy;
        logic [CNT_W-1:0] pend;
    } vec_t;

    vec_t vt[22];

    cdc_pulse_tx #(.SYNC_STAGES(2), .CNT_W(CNT_W), .TMO_W(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sig_in   (sig_in),
        .ack_in   (ack_in),
        .req_out  (req_out),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .ovf      (ovf),
        .tmo      (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // one clock: receiver model returns req_out as ack_in three edges later
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rstn) ack_d = '0;
        else       ack_d = {ack_d[1:0], req_out & lb_en};
        ack_in = ack_d[2];
        if (req_out && !prev_req) edges++;
        prev_req = req_out;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int e0;
        int peak;

        // single pulse, then a pulse that coincides with ack_s falling in DROP
        vt[0]  = '{1'b1, 1'b1, 1'b1, 4'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 4'd0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 4'd0};
        vt[12] = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[13] = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[14] = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[15] = '{1'b0, 1'b1, 1'b1, 4'd0};
        vt[16] = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[17] = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[18] = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[19] = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[20] = '{1'b0, 1'b0, 1'b1, 4'd0};
        vt[21] = '{1'b1, 1'b1, 1'b1, 4'd0};

        rstn   = 1'b0;
        sig_in = 1'b0;
        ack_in = 1'b0;
        ack_d  = '0;
        lb_en  = 1'b1;
        tick();
        tick();
        chk("rst_req",  req_out,  1'b0);
        chk("rst_busy", busy,     1'b0);
        chk("rst_pend", pend_cnt, 4'd0);
        chk("rst_ovf",  ovf,      1'b0);
        chk("rst_tmo",  tmo,      1'b0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            sig_in = vt[i].sig;
            tick();
            chk($sformatf("vec%0d_req", i),  req_out,  vt[i].req);
            chk($sformatf("vec%0d_busy", i), busy,     vt[i].bsy);
            chk($sformatf("vec%0d_pend", i), pend_cnt, vt[i].pend);
        end
        sig_in = 1'b0;
        drain(ok);
        chk("coinc_drain", ok, 1'b1);

        // burst of five back-to-back pulses
        e0   = edges;
        peak = 0;
        for (int i = 0; i < 5; i++) begin
            sig_in = 1'b1;
            tick();
            if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
        end
        sig_in = 1'b0;
        chk("burst_pend4", pend_cnt, 4'd4);
        drain(ok);
        chk("burst_drain", ok, 1'b1);
        chk("burst_peak",  peak, 4);
        chk("burst_edges", edges - e0, 5);
        chk("burst_pend0", pend_cnt, 4'd0);
        chk("burst_ovf",   ovf, 1'b0);

        // saturation with the ack held low
        lb_en = 1'b0;
        e0    = edges;
        for (int i = 0; i < 20; i++) begin
            sig_in = 1'b1;
            tick();
            if (i == 15) begin
                chk("sat_edge_pend", pend_cnt, 4'd15);
                chk("sat_edge_ovf",  ovf, 1'b0);
            end
        end
        sig_in = 1'b0;
        chk("sat_pend", pend_cnt, 4'd15);
        chk("sat_ovf",  ovf, 1'b1);
        chk("sat_req",  req_out, 1'b1);
        chk("tmo_zero", tmo, 1'b0);
        lb_en = 1'b1;
        drain(ok);
        chk("sat_drain", ok, 1'b1);
        chk("sat_edges", edges - e0, 16);
        chk("sat_pend0", pend_cnt, 4'd0);
        chk("sat_ovf_sticky", ovf, 1'b1);

        // asynchronous reset in the middle of a handshake
        lb_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sig_in = 1'b1;
            tick();
        end
        sig_in = 1'b0;
        chk("mid_pend3", pend_cnt, 4'd3);
        chk("mid_req",   req_out, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_req",  req_out,  1'b0);
        chk("arst_pend", pend_cnt, 4'd0);
        chk("arst_busy", busy,     1'b0);
        chk("arst_ovf",  ovf,      1'b0);
        tick();
        @(negedge clk);
        rstn  = 1'b1;
        lb_en = 1'b1;
        tick();
        chk("post_rst_busy", busy, 1'b0);

`ifdef CDC_PULSE_TX_TIMEOUT_EN
        lb_en  = 1'b0;
        sig_in = 1'b1;
        tick();
        sig_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!req_out) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tmo_abort", ok, 1'b1);
        chk("tmo_flag",  tmo, 1'b1);
        chk("tmo_busy",  busy, 1'b0);
        chk("tmo_pend",  pend_cnt, 4'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
